// File: rtl/ysyx_22041752_ms_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041752_ms_pkg
// Purpose  : Shared types and helpers for the ysyx_22041752 memory-access
//            stage: access-size encodings, the stage state enum, the
//            XLEN-dependent address-offset width and the access fault check.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ysyx_22041752_ms_pkg;

  // Access size carried on es_mem_bytes.
  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;
  localparam logic [1:0] MEM_D = 2'b11;

  typedef enum logic [1:0] {
    MS_EMPTY = 2'd0,
    MS_WAIT  = 2'd1,
    MS_DONE  = 2'd2,
    MS_DRAIN = 2'd3
  } ms_state_e;

  // Number of address bits selecting a byte lane inside one XLEN word.
  function automatic int offset_width(input int xlen);
    return $clog2(xlen / 8);
  endfunction

  // An access faults when its byte offset is not a multiple of its size.
  // A doubleword access on a 32-bit datapath has no legal encoding at all.
  function automatic logic access_fault(input logic [1:0] bytes,
                                        input logic [2:0] off,
                                        input logic       xlen32);
    logic fault;
    case (bytes)
      MEM_B:   fault = 1'b0;
      MEM_H:   fault = off[0];
      MEM_W:   fault = |off[1:0];
      default: fault = xlen32 | (|off);
    endcase
    return fault;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_22041752_load_extract.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041752_load_extract
// Purpose  : Combinational load-data alignment. Shifts the aligned memory
//            word down to the addressed byte lane, keeps 8/16/32/64 bits and
//            sign- or zero-extends to XLEN; also flags faulting accesses.
// Ports    : rdata     - aligned memory word
//            offset    - byte offset inside the word
//            mem_bytes - access size (B/H/W/D)
//            sext      - sign-extend when set, zero-extend otherwise
//            is_mem    - instruction is a load or store
//            load_data - extracted, extended load value
//            excp      - misaligned or illegal-size memory access
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22041752_load_extract
  import ysyx_22041752_ms_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int OFF_W = offset_width(XLEN)
) (
  input  logic [XLEN-1:0]  rdata,
  input  logic [OFF_W-1:0] offset,
  input  logic [1:0]       mem_bytes,
  input  logic             sext,
  input  logic             is_mem,
  output logic [XLEN-1:0]  load_data,
  output logic             excp
);

  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_size_mask;
  logic            w_sign_bit;

  assign w_shifted = rdata >> {offset, 3'b000};

  // Extension is done with a mask rather than replication so the same code
  // is legal for every XLEN (no zero-width replications at the top size).
  always_comb begin
    w_size_mask = '1;
    w_sign_bit  = w_shifted[XLEN-1];
    case (mem_bytes)
      MEM_B: begin
        w_size_mask = XLEN'(8'hFF);
        w_sign_bit  = w_shifted[7];
      end
      MEM_H: begin
        w_size_mask = XLEN'(16'hFFFF);
        w_sign_bit  = w_shifted[15];
      end
      MEM_W: begin
        w_size_mask = XLEN'(32'hFFFF_FFFF);
        w_sign_bit  = w_shifted[31];
      end
      default: begin
        w_size_mask = '1;
        w_sign_bit  = w_shifted[XLEN-1];
      end
    endcase
    load_data = (w_shifted & w_size_mask) | ((sext & w_sign_bit) ? ~w_size_mask : '0);
  end

  assign excp = is_mem & access_fault(mem_bytes, 3'(offset), XLEN == 32);

endmodule
`default_nettype wire

// File: rtl/ysyx_22041752_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041752_mem_stage
// Purpose  : MS pipeline stage between EX and WB. Waits for the data memory
//            response (data_rvalid), buffers it while WB stalls, extracts
//            load data, flags faulting accesses, drives the forward bus and
//            drains an in-flight response after a flush.
// Ports    : clk/reset                 - clock, synchronous active-high reset
//            es_to_ms_valid/ms_allowin - EX -> MS handshake
//            es_*                      - instruction fields from EX
//            data_rvalid/data_rdata    - memory response
//            ms_flush                  - kill MS contents
//            ws_allowin/ms_to_ws_valid - MS -> WB handshake
//            ms_rf_we..ms_excp         - fields to WB
//            ms_fwd_*                  - forward bus
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22041752_mem_stage
  import ysyx_22041752_ms_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int RF_ADDR_WD = 5,
  parameter int PC_WD      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  es_to_ms_valid,
  output logic                  ms_allowin,
  input  logic [PC_WD-1:0]      es_pc,
  input  logic [XLEN-1:0]       es_alu_result,
  input  logic [RF_ADDR_WD-1:0] es_rd,
  input  logic                  es_rf_we,
  input  logic                  es_mem_re,
  input  logic                  es_mem_we,
  input  logic                  es_sext,
  input  logic [1:0]            es_mem_bytes,
  input  logic                  data_rvalid,
  input  logic [XLEN-1:0]       data_rdata,
  input  logic                  ms_flush,
  input  logic                  ws_allowin,
  output logic                  ms_to_ws_valid,
  output logic                  ms_rf_we,
  output logic [RF_ADDR_WD-1:0] ms_rd,
  output logic [XLEN-1:0]       ms_result,
  output logic [PC_WD-1:0]      ms_pc,
  output logic                  ms_excp,
  output logic                  ms_fwd_valid,
  output logic                  ms_fwd_pending,
  output logic [RF_ADDR_WD-1:0] ms_fwd_rd,
  output logic [XLEN-1:0]       ms_fwd_data
);

  localparam int OFF_W = offset_width(XLEN);

  ms_state_e             state_q, state_d;
  logic [PC_WD-1:0]      pc_q, pc_d;
  logic [XLEN-1:0]       alu_q, alu_d;
  logic [XLEN-1:0]       rdata_q, rdata_d;
  logic [RF_ADDR_WD-1:0] rd_q, rd_d;
  logic                  rf_we_q, rf_we_d;
  logic                  mem_re_q, mem_re_d;
  logic                  mem_we_q, mem_we_d;
  logic                  sext_q, sext_d;
  logic [1:0]            bytes_q, bytes_d;

  logic            w_busy;
  logic            w_handoff;
  logic            w_accept;
  logic            w_new_fault;
  ms_state_e       w_new_state;
  logic [XLEN-1:0] w_rdata_sel;
  logic [XLEN-1:0] w_load_data;
  logic            w_excp;

  // In WAIT the live response is used so a load completes with no extra
  // cycle; once captured, DONE works from the buffered copy.
  assign w_rdata_sel = (state_q == MS_WAIT) ? data_rdata : rdata_q;

  ysyx_22041752_load_extract #(
    .XLEN  (XLEN),
    .OFF_W (OFF_W)
  ) u_load_extract (
    .rdata     (w_rdata_sel),
    .offset    (alu_q[OFF_W-1:0]),
    .mem_bytes (bytes_q),
    .sext      (sext_q),
    .is_mem    (mem_re_q | mem_we_q),
    .load_data (w_load_data),
    .excp      (w_excp)
  );

  assign w_busy         = (state_q == MS_WAIT) | (state_q == MS_DONE);
  assign ms_excp        = w_excp & w_busy;
  assign ms_rf_we       = rf_we_q & ~ms_excp;
  assign ms_rd          = rd_q;
  assign ms_pc          = pc_q;
  assign ms_result      = mem_re_q ? w_load_data : alu_q;
  assign ms_to_ws_valid = ~ms_flush & ((state_q == MS_DONE) |
                                       ((state_q == MS_WAIT) & data_rvalid));

  assign ms_fwd_valid   = ms_rf_we & w_busy;
  assign ms_fwd_pending = mem_re_q & (state_q == MS_WAIT) & ~data_rvalid;
  assign ms_fwd_rd      = rd_q;
  assign ms_fwd_data    = ms_result;

  assign w_handoff  = ms_to_ws_valid & ws_allowin;
  assign ms_allowin = ~ms_flush & (state_q != MS_DRAIN) &
                      ((state_q == MS_EMPTY) | w_handoff);
  assign w_accept   = es_to_ms_valid & ms_allowin;

  // A faulting memory op is never issued to memory, so it goes straight to
  // DONE instead of waiting for a response that will not come.
  assign w_new_fault = access_fault(es_mem_bytes, 3'(es_alu_result[OFF_W-1:0]), XLEN == 32);
  assign w_new_state = ((es_mem_re | es_mem_we) & ~w_new_fault) ? MS_WAIT : MS_DONE;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    alu_d    = alu_q;
    rdata_d  = rdata_q;
    rd_d     = rd_q;
    rf_we_d  = rf_we_q;
    mem_re_d = mem_re_q;
    mem_we_d = mem_we_q;
    sext_d   = sext_q;
    bytes_d  = bytes_q;

    if (w_accept) begin
      pc_d     = es_pc;
      alu_d    = es_alu_result;
      rd_d     = es_rd;
      rf_we_d  = es_rf_we;
      mem_re_d = es_mem_re;
      mem_we_d = es_mem_we;
      sext_d   = es_sext;
      bytes_d  = es_mem_bytes;
    end

    // data_rvalid outside WAIT/DRAIN is ignored on purpose.
    case (state_q)
      MS_EMPTY: begin
        if (!ms_flush && w_accept) state_d = w_new_state;
      end
      MS_WAIT: begin
        if (ms_flush) begin
          // A response arriving with the flush is consumed here; otherwise
          // it is still owed and must be swallowed in DRAIN.
          state_d = data_rvalid ? MS_EMPTY : MS_DRAIN;
        end else if (data_rvalid) begin
          rdata_d = data_rdata;
          if (w_handoff) state_d = w_accept ? w_new_state : MS_EMPTY;
          else           state_d = MS_DONE;
        end
      end
      MS_DONE: begin
        if (ms_flush)       state_d = MS_EMPTY;
        else if (w_handoff) state_d = w_accept ? w_new_state : MS_EMPTY;
      end
      MS_DRAIN: begin
        if (data_rvalid) state_d = MS_EMPTY;
      end
      default: state_d = MS_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= MS_EMPTY;
      pc_q     <= '0;
      alu_q    <= '0;
      rdata_q  <= '0;
      rd_q     <= '0;
      rf_we_q  <= 1'b0;
      mem_re_q <= 1'b0;
      mem_we_q <= 1'b0;
      sext_q   <= 1'b0;
      bytes_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      alu_q    <= alu_d;
      rdata_q  <= rdata_d;
      rd_q     <= rd_d;
      rf_we_q  <= rf_we_d;
      mem_re_q <= mem_re_d;
      mem_we_q <= mem_we_d;
      sext_q   <= sext_d;
      bytes_q  <= bytes_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041752_mem_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22041752_mem_stage
// Purpose  : Directed self-checking bench for ysyx_22041752_mem_stage
//            (XLEN=64 main instance plus an XLEN=32 instance for the
//            illegal doubleword case). Expected WB outputs are queued when
//            an op is driven and popped when MS hands off to WB.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041752_mem_stage;
  import ysyx_22041752_ms_pkg::*;

  logic        clk;
  logic        reset;
  logic        es_to_ms_valid;
  logic        es_to_ms_valid32;
  logic [63:0] es_pc;
  logic [63:0] es_alu_result;
  logic [4:0]  es_rd;
  logic        es_rf_we, es_mem_re, es_mem_we, es_sext;
  logic [1:0]  es_mem_bytes;
  logic        data_rvalid;
  logic [63:0] data_rdata;
  logic        ms_flush;
  logic        ws_allowin;
  logic        ws_allowin32;

  logic        ms_allowin, ms_to_ws_valid, ms_rf_we, ms_excp;
  logic [4:0]  ms_rd, ms_fwd_rd;
  logic [63:0] ms_result, ms_pc, ms_fwd_data;
  logic        ms_fwd_valid, ms_fwd_pending;

  logic        ms_allowin32, ms_to_ws_valid32, ms_rf_we32, ms_excp32;
  logic [4:0]  ms_rd32, ms_fwd_rd32;
  logic [31:0] ms_result32, ms_fwd_data32;
  logic [63:0] ms_pc32;
  logic        ms_fwd_valid32, ms_fwd_pending32;

  ysyx_22041752_mem_stage #(.XLEN(64), .RF_ADDR_WD(5), .PC_WD(64)) dut (
    .clk(clk), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid), .ms_allowin(ms_allowin),
    .es_pc(es_pc), .es_alu_result(es_alu_result), .es_rd(es_rd),
    .es_rf_we(es_rf_we), .es_mem_re(es_mem_re), .es_mem_we(es_mem_we),
    .es_sext(es_sext), .es_mem_bytes(es_mem_bytes),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .ms_flush(ms_flush), .ws_allowin(ws_allowin),
    .ms_to_ws_valid(ms_to_ws_valid), .ms_rf_we(ms_rf_we), .ms_rd(ms_rd),
    .ms_result(ms_result), .ms_pc(ms_pc), .ms_excp(ms_excp),
    .ms_fwd_valid(ms_fwd_valid), .ms_fwd_pending(ms_fwd_pending),
    .ms_fwd_rd(ms_fwd_rd), .ms_fwd_data(ms_fwd_data)
  );

  ysyx_22041752_mem_stage #(.XLEN(32), .RF_ADDR_WD(5), .PC_WD(64)) dut32 (
    .clk(clk), .reset(reset),
    .es_to_ms_valid(es_to_ms_valid32), .ms_allowin(ms_allowin32),
    .es_pc(es_pc), .es_alu_result(es_alu_result[31:0]), .es_rd(es_rd),
    .es_rf_we(es_rf_we), .es_mem_re(es_mem_re), .es_mem_we(es_mem_we),
    .es_sext(es_sext), .es_mem_bytes(es_mem_bytes),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata[31:0]),
    .ms_flush(ms_flush), .ws_allowin(ws_allowin32),
    .ms_to_ws_valid(ms_to_ws_valid32), .ms_rf_we(ms_rf_we32), .ms_rd(ms_rd32),
    .ms_result(ms_result32), .ms_pc(ms_pc32), .ms_excp(ms_excp32),
    .ms_fwd_valid(ms_fwd_valid32), .ms_fwd_pending(ms_fwd_pending32),
    .ms_fwd_rd(ms_fwd_rd32), .ms_fwd_data(ms_fwd_data32)
  );

  typedef struct {
    logic [63:0] pc;
    logic [4:0]  rd;
    logic [63:0] res;
    logic        rf_we;
    logic        excp;
    logic        chk_res;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [63:0] pc, input logic [63:0] alu, input logic [4:0] rd,
                          input logic rf_we, input logic re, input logic we, input logic sext,
                          input logic [1:0] bytes);
    es_to_ms_valid = 1'b1;
    es_pc          = pc;
    es_alu_result  = alu;
    es_rd          = rd;
    es_rf_we       = rf_we;
    es_mem_re      = re;
    es_mem_we      = we;
    es_sext        = sext;
    es_mem_bytes   = bytes;
  endtask

  task automatic push_exp(input logic [63:0] pc, input logic [4:0] rd, input logic [63:0] res,
                          input logic rf_we, input logic excp, input logic chk_res);
    exp_t e;
    e.pc = pc; e.rd = rd; e.res = res; e.rf_we = rf_we; e.excp = excp; e.chk_res = chk_res;
    sb.push_back(e);
  endtask

  // Scoreboard consumer: every MS->WB handoff must match the oldest entry.
  always @(negedge clk) begin
    if (!reset && ms_to_ws_valid && ws_allowin) begin
      if (sb.size() == 0) begin
        check("unexpected_output", {63'd0, ms_to_ws_valid}, 64'd0);
      end else begin : pop_blk
        exp_t e;
        e = sb.pop_front();
        check("out_pc",    ms_pc,    e.pc);
        check("out_rd",    {59'd0, ms_rd}, {59'd0, e.rd});
        check("out_rf_we", {63'd0, ms_rf_we}, {63'd0, e.rf_we});
        check("out_excp",  {63'd0, ms_excp},  {63'd0, e.excp});
        if (e.chk_res) check("out_result", ms_result, e.res);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_valid32 = 1'b0;
    es_pc = '0; es_alu_result = '0; es_rd = '0; es_rf_we = 1'b0; es_mem_re = 1'b0;
    es_mem_we = 1'b0; es_sext = 1'b0; es_mem_bytes = MEM_B;
    data_rvalid = 1'b0; data_rdata = '0; ms_flush = 1'b0;
    ws_allowin = 1'b1; ws_allowin32 = 1'b0;
    next(); next();
    reset = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_allowin",   {63'd0, ms_allowin}, 64'd1);
    check("rst_valid",     {63'd0, ms_to_ws_valid}, 64'd0);
    check("rst_fwd_valid", {63'd0, ms_fwd_valid}, 64'd0);
    check("rst_pending",   {63'd0, ms_fwd_pending}, 64'd0);
    check("rst_excp",      {63'd0, ms_excp}, 64'd0);
    check("rst_pc",        ms_pc, 64'd0);
    check("rst_result",    ms_result, 64'd0);
    check("rst_allowin32", {63'd0, ms_allowin32}, 64'd1);

    // Three back-to-back ALU ops, one handoff per cycle
    drive_op(64'h100, 64'h11, 5'd1, 1'b1, 1'b0, 1'b0, 1'b0, MEM_D);
    push_exp(64'h100, 5'd1, 64'h11, 1'b1, 1'b0, 1'b1);
    next();
    drive_op(64'h104, 64'h22, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, MEM_D);
    push_exp(64'h104, 5'd2, 64'h22, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("b2b_valid_a",   {63'd0, ms_to_ws_valid}, 64'd1);
    check("b2b_allowin_a", {63'd0, ms_allowin}, 64'd1);
    next();
    drive_op(64'h108, 64'h33, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, MEM_D);
    push_exp(64'h108, 5'd3, 64'h33, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("b2b_allowin_b", {63'd0, ms_allowin}, 64'd1);
    next();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    check("b2b_pc_c", ms_pc, 64'h108);
    next();
    @(negedge clk);
    check("b2b_idle_valid", {63'd0, ms_to_ws_valid}, 64'd0);

    // lb, offset 3, sign-extended
    next();
    drive_op(64'h200, 64'h1003, 5'd5, 1'b1, 1'b1, 1'b0, 1'b1, MEM_B);
    next();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    check("lb_pending",    {63'd0, ms_fwd_pending}, 64'd1);
    check("lb_fwd_valid",  {63'd0, ms_fwd_valid}, 64'd1);
    check("lb_fwd_rd",     {59'd0, ms_fwd_rd}, 64'd5);
    check("lb_wait_valid", {63'd0, ms_to_ws_valid}, 64'd0);
    check("lb_wait_allow", {63'd0, ms_allowin}, 64'd0);
    next();
    data_rvalid = 1'b1; data_rdata = 64'h0000_0000_8000_0000;
    push_exp(64'h200, 5'd5, 64'hFFFF_FFFF_FFFF_FF80, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("lb_fwd_data",   ms_fwd_data, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_pending_rv", {63'd0, ms_fwd_pending}, 64'd0);
    next();
    data_rvalid = 1'b0;
    @(negedge clk);
    check("lb_allow_after", {63'd0, ms_allowin}, 64'd1);

    // lhu, offset 6, response at N+3, WB stalled until N+5
    next();
    drive_op(64'h300, 64'h2006, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0, MEM_H);
    next();
    es_to_ms_valid = 1'b0; ws_allowin = 1'b0;
    @(negedge clk);
    check("lhu_pending_n", {63'd0, ms_fwd_pending}, 64'd1);
    next();
    @(negedge clk);
    check("lhu_pending_n1", {63'd0, ms_fwd_pending}, 64'd1);
    next();
    @(negedge clk);
    check("lhu_pending_n2", {63'd0, ms_fwd_pending}, 64'd1);
    next();
    data_rvalid = 1'b1; data_rdata = 64'hBEEF_0000_0000_0000;
    push_exp(64'h300, 5'd6, 64'h0000_0000_0000_BEEF, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("lhu_valid_n3",  {63'd0, ms_to_ws_valid}, 64'd1);
    check("lhu_result_n3", ms_result, 64'h0000_0000_0000_BEEF);
    check("lhu_allow_n3",  {63'd0, ms_allowin}, 64'd0);
    next();
    data_rvalid = 1'b0; data_rdata = 64'h1234_5678_9ABC_DEF0;
    @(negedge clk);
    check("lhu_valid_n4",   {63'd0, ms_to_ws_valid}, 64'd1);
    check("lhu_result_n4",  ms_result, 64'h0000_0000_0000_BEEF);
    check("lhu_allow_n4",   {63'd0, ms_allowin}, 64'd0);
    check("lhu_pending_n4", {63'd0, ms_fwd_pending}, 64'd0);
    next();
    ws_allowin = 1'b1;
    drive_op(64'h304, 64'h55, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, MEM_B);
    push_exp(64'h304, 5'd9, 64'h55, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    check("lhu_result_n5", ms_result, 64'h0000_0000_0000_BEEF);
    check("lhu_allow_n5",  {63'd0, ms_allowin}, 64'd1);
    next();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    check("after_stall_pc", ms_pc, 64'h304);

    // Misaligned lw at 0x1002
    next();
    drive_op(64'h400, 64'h1002, 5'd10, 1'b1, 1'b1, 1'b0, 1'b1, MEM_W);
    push_exp(64'h400, 5'd10, 64'd0, 1'b0, 1'b1, 1'b0);
    next();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    check("mis_excp",      {63'd0, ms_excp}, 64'd1);
    check("mis_rf_we",     {63'd0, ms_rf_we}, 64'd0);
    check("mis_valid",     {63'd0, ms_to_ws_valid}, 64'd1);
    check("mis_pending",   {63'd0, ms_fwd_pending}, 64'd0);
    next();
    @(negedge clk);
    check("mis_allow_after", {63'd0, ms_allowin}, 64'd1);
    check("mis_idle_valid",  {63'd0, ms_to_ws_valid}, 64'd0);

    // Aligned sd: waits for the store ack, no register write
    next();
    drive_op(64'h500, 64'h3008, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, MEM_D);
    push_exp(64'h500, 5'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    next();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    check("sd_wait_valid", {63'd0, ms_to_ws_valid}, 64'd0);
    check("sd_pending",    {63'd0, ms_fwd_pending}, 64'd0);
    next();
    data_rvalid = 1'b1;
    @(negedge clk);
    check("sd_ack_valid", {63'd0, ms_to_ws_valid}, 64'd1);
    next();
    data_rvalid = 1'b0;

    // Flush in WAIT, response two cycles after the flush is drained
    drive_op(64'h600, 64'h4000, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0, MEM_D);
    next();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    check("fl_wait_pending", {63'd0, ms_fwd_pending}, 64'd1);
    next();
    ms_flush = 1'b1;
    @(negedge clk);
    check("fl_allow",  {63'd0, ms_allowin}, 64'd0);
    check("fl_valid",  {63'd0, ms_to_ws_valid}, 64'd0);
    next();
    ms_flush = 1'b0;
    drive_op(64'h700, 64'h77, 5'd11, 1'b1, 1'b0, 1'b0, 1'b0, MEM_B);
    @(negedge clk);
    check("drain_allow",     {63'd0, ms_allowin}, 64'd0);
    check("drain_valid",     {63'd0, ms_to_ws_valid}, 64'd0);
    check("drain_fwd_valid", {63'd0, ms_fwd_valid}, 64'd0);
    next();
    data_rvalid = 1'b1; data_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    @(negedge clk);
    check("drain_rv_allow", {63'd0, ms_allowin}, 64'd0);
    check("drain_rv_valid", {63'd0, ms_to_ws_valid}, 64'd0);
    next();
    data_rvalid = 1'b0; es_to_ms_valid = 1'b0;
    @(negedge clk);
    check("drain_done_allow", {63'd0, ms_allowin}, 64'd1);

    // Flush together with es_to_ms_valid: op is not latched
    next();
    drive_op(64'h800, 64'h88, 5'd12, 1'b1, 1'b0, 1'b0, 1'b0, MEM_B);
    ms_flush = 1'b1;
    @(negedge clk);
    check("flacc_allow", {63'd0, ms_allowin}, 64'd0);
    next();
    es_to_ms_valid = 1'b0; ms_flush = 1'b0;
    @(negedge clk);
    check("flacc_valid", {63'd0, ms_to_ws_valid}, 64'd0);
    check("flacc_allow_after", {63'd0, ms_allowin}, 64'd1);

    // Flush together with rvalid in WAIT: response consumed, no output
    next();
    drive_op(64'h900, 64'h5000, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0, MEM_D);
    next();
    es_to_ms_valid = 1'b0;
    @(negedge clk);
    check("flrv_pending", {63'd0, ms_fwd_pending}, 64'd1);
    next();
    ms_flush = 1'b1; data_rvalid = 1'b1;
    @(negedge clk);
    check("flrv_valid", {63'd0, ms_to_ws_valid}, 64'd0);
    next();
    ms_flush = 1'b0; data_rvalid = 1'b0;
    @(negedge clk);
    check("flrv_allow_after", {63'd0, ms_allowin}, 64'd1);
    check("flrv_idle_valid",  {63'd0, ms_to_ws_valid}, 64'd0);

    // XLEN=32: ld has no legal encoding
    next();
    drive_op(64'hA00, 64'h0, 5'd14, 1'b1, 1'b1, 1'b0, 1'b0, MEM_D);
    es_to_ms_valid   = 1'b0;
    es_to_ms_valid32 = 1'b1;
    next();
    es_to_ms_valid32 = 1'b0;
    @(negedge clk);
    check("x32_ld_excp",  {63'd0, ms_excp32}, 64'd1);
    check("x32_ld_valid", {63'd0, ms_to_ws_valid32}, 64'd1);
    check("x32_ld_rf_we", {63'd0, ms_rf_we32}, 64'd0);

    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ysyx_22041752_mem_stage.md
# ysyx_22041752_mem_stage

Parametrised memory-access (MS) pipeline stage for the ysyx_22041752 core. It sits between EX and WB and receives load/store instructions already issued to the data memory by EX. It waits for the memory response on a valid handshake, not a miss flag, and buffers the response while WB stalls. It also extracts and extends load data for any XLEN, flags misaligned accesses, exports a forward bus with a load-pending indication, and safely drains an in-flight response when the stage is flushed.

## Interface
Parameters:
- XLEN, 64, datapath width; 32 or 64
- RF_ADDR_WD, 5, register index width
- PC_WD, 64, PC width

Ports (reset: one clock; reset is synchronous and active-high):
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- es_to_ms_valid  in  1  EX holds a valid instruction
- ms_allowin  out  1  MS accepts from EX this cycle
- es_pc / es_alu_result / es_rd  in  PC_WD / XLEN / RF_ADDR_WD  instruction fields; alu_result is the address for memory ops
- es_rf_we, es_mem_re, es_mem_we, es_sext  in  1 each  control
- es_mem_bytes  in  2  00 byte, 01 half, 10 word, 11 double
- data_rvalid  in  1  memory response for the oldest issued op (load data or store ack)
- data_rdata  in  XLEN  aligned memory word
- ms_flush  in  1  kill MS contents
- ws_allowin  in  1  WB accepts
- ms_to_ws_valid  out  1
- ms_rf_we, ms_rd, ms_result, ms_pc, ms_excp  out  1/RF_ADDR_WD/XLEN/PC_WD/1  to WB
- ms_fwd_valid, ms_fwd_pending, ms_fwd_rd, ms_fwd_data  out  1/1/RF_ADDR_WD/XLEN  forward bus

## Operation
- State machine with states EMPTY, WAIT, DONE, DRAIN:
  - EMPTY → DONE on accepting a non-memory op or a misaligned op.
  - EMPTY → WAIT on accepting an aligned memory op.
  - WAIT → DONE on data_rvalid; the response is captured.
  - DONE → EMPTY or DONE on handoff: EMPTY if nothing is accepted, or the next state for the accepted op.
  - WAIT + ms_flush → DRAIN.
  - DRAIN → EMPTY on data_rvalid; the data is discarded.
  - ms_flush in EMPTY or DONE → EMPTY.
- Accept rule: ms_allowin = (state==EMPTY) | (ms_to_ws_valid & ws_allowin); forced 0 in DRAIN and when ms_flush.
- ms_to_ws_valid = !ms_flush & (DONE | (WAIT & data_rvalid)). WAIT with rvalid forwards the live rdata combinationally, with zero added latency. Captured data is used in DONE.
- Load extract:
  - offset = alu_result[log2(XLEN/8)-1:0]
  - shift rdata right by offset*8
  - take the low 8/16/32/64 bits, then sign-extend if es_sext, else zero-extend
  - XLEN=32 with bytes=11 is treated as illegal: ms_excp=1.
- Misalign: for a memory op, ms_excp=1 when offset is not a multiple of the size. EX does not issue such an op, so no response is expected. ms_rf_we is forced 0 for it.
- ms_result = mem_re ? extracted load : alu_result. Store results are don't-care with rf_we=0.
- Forward bus:
  - ms_fwd_valid = rf_we & state∈{WAIT,DONE}
  - ms_fwd_pending = mem_re & state==WAIT & !data_rvalid
  - ms_fwd_data = ms_result
- data_rvalid in EMPTY or DONE is a protocol violation: ignored, state unchanged.

## Timing
- Reset: state EMPTY; ms_to_ws_valid=0, ms_fwd_valid=0, ms_fwd_pending=0, ms_excp=0, and all stored fields 0. ms_allowin=1 the first cycle after reset.
- Non-memory op: latched at edge N, ms_to_ws_valid in cycle N.
- Load: latched at edge N, rvalid earliest in cycle N+1. The result is presented that same cycle.
- WB stall with rvalid: data captured at the edge, and the result is held stable in DONE until ws_allowin.
- Back-to-back: while handing off in DONE, a new op is accepted in the same cycle, giving full throughput.
- Flush in the same cycle as es_to_ms_valid: flush wins and the new op is not latched.
- Flush in the same cycle as rvalid in WAIT: state → EMPTY, the response is consumed, and there is no output.
- Reset mid-WAIT: EMPTY. The memory side must be reset together with this stage.

## Structure
- Package ysyx_22041752_ms_pkg holds:
  - the MEM_BYTES encodings (B/H/W/D)
  - the state enum (EMPTY/WAIT/DONE/DRAIN)
  - the XLEN-dependent offset width function
- Sub-module ysyx_22041752_load_extract holds the combinational shift, size select, extension and misalign check, parametrised by XLEN.

## Test plan
- XLEN=64:
  - lb with addr offset 3 and rdata=0x0000_0000_8000_0000 → ms_result=0xFFFF_FFFF_FFFF_FF80.
  - lhu with offset 6 and rdata=0xBEEF_0000_0000_0000 → 0x0000_0000_0000_BEEF.
- Load latched at edge N, rvalid at N+3 with ws_allowin=0 until N+5:
  - ms_fwd_pending=1 in N+1..N+2
  - ms_to_ws_valid asserted from N+3, result stable N+3..N+5
  - ms_allowin=0 in N+3..N+4
- lw at address 0x1002: ms_excp=1 and ms_rf_we=0 in the cycle after acceptance; no response is awaited.
- Flush in WAIT, then rvalid two cycles later:
  - ms_allowin=0 throughout
  - the discarded response produces no ms_to_ws_valid
  - ms_allowin=1 in the cycle after rvalid
- Three back-to-back ALU ops with ws_allowin=1: one output per cycle with matching pc and rd.
- XLEN=32 with ld (bytes=11): ms_excp=1.
